imem_load_controller: RTL

- Sequences the single-cycle MIPS core's instruction memory between two modes: host program load and processor execution.
- While loading, it accepts 32-bit words from a host over a valid/ready handshake, writes them at auto-incrementing, word-stepped addresses and holds the core in clear.
- While running, it passes the PC fetch address to the memory and releases the core. It supports halt/resume and counts run cycles.

---
 rtl/imem_ctl_pkg.sv | 22 ++
 rtl/sat_counter.sv | 22 ++
 rtl/imem_load_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/imem_ctl_pkg.sv
// rtl/imem_ctl_pkg.sv - shared types, defaults and capacity helper for the imem load controller
package imem_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_STEP = 4;
  localparam int DEF_LOAD_BASE = 0;
  localparam int DEF_CNT_W     = 16;

  // Number of word slots reachable before the address pointer wraps.
  function automatic int max_words(input int addr_w, input int step);
    return (1 << addr_w) / step;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable and synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/imem_load_controller.sv
// rtl/imem_load_controller.sv - instruction memory sequencer: host program load versus core execution
module imem_load_controller
  import imem_ctl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_STEP = DEF_ADDR_STEP,
  parameter int LOAD_BASE = DEF_LOAD_BASE,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_start,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_clr,
  output logic              cpu_run,
  output logic [ADDR_W:0]   words_loaded,
  output logic              load_done,
  output logic              load_err,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam int                MAX_WORDS = max_words(ADDR_W, ADDR_STEP);
  localparam logic [ADDR_W:0]   LAST_SLOT = (ADDR_W+1)'(MAX_WORDS - 1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

  state_t              state, next_state;
  logic [ADDR_W-1:0]   addr_ptr;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                xfer;
  logic                at_last_slot;
  logic                load_go;

  assign xfer         = (state == LOAD) && host_valid && host_ready;
  assign at_last_slot = (words_loaded == LAST_SLOT);
  assign load_go      = (next_state == LOAD) && (state != LOAD);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load_start)                    next_state = LOAD;
        else if (run_req && (words_loaded != '0)) next_state = RUN;
      end
      LOAD: begin
        // Either an explicit end-of-program or running out of address space ends the load.
        if (xfer && (host_last || at_last_slot)) next_state = IDLE;
      end
      RUN: begin
        if (halt_req) next_state = HALT;
      end
      HALT: begin
        if (load_start)   next_state = LOAD;
        else if (run_req) next_state = RUN;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      host_ready   <= 1'b0;
      cpu_clr      <= 1'b1;
      cpu_run      <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      addr_ptr     <= BASE;
      words_loaded <= '0;
    end else begin
      host_ready <= (next_state == LOAD);
      cpu_run    <= (next_state == RUN);
      if (next_state == LOAD)     cpu_clr <= 1'b1;
      else if (next_state == RUN) cpu_clr <= 1'b0;
      load_done <= xfer && host_last;
      wr_en     <= xfer;
      if (load_go) begin
        addr_ptr     <= BASE;
        words_loaded <= '0;
        load_err     <= 1'b0;
      end else if (xfer) begin
        wr_addr      <= addr_ptr;
        wr_data      <= host_data;
        addr_ptr     <= addr_ptr + STEP;
        words_loaded <= words_loaded + CNT_ONE;
        if (at_last_slot && !host_last) load_err <= 1'b1;
      end
    end
  end

  // In RUN the core owns the address bus with no added latency.
  assign mem_en   = (state == RUN) || wr_en;
  assign mem_wen  = wr_en;
  assign mem_addr = (state == RUN) ? fetch_addr : wr_addr;
  assign mem_data = wr_data;

  sat_counter #(
    .W(CNT_W)
  ) u_run_cnt (
    .clk  (clk),
    .rst_n(clr),
    .en   (state == RUN),
    .clear(load_go),
    .cnt  (run_cycles)
  );

endmodule
